// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared FSM encoding, NOP constant and instruction field positions for the fetch unit
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FIELD_MSB  = 25;
  localparam int FIELD_LSB  = 0;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

endpackage

// File: rtl/ifu_timeout_ctr.sv
// rtl/ifu_timeout_ctr.sv - REQ wait counter; expire flags the last permitted REQ cycle without ack
module ifu_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (count) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt holds the number of unacked REQ cycles already elapsed
  assign expire = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch FSM with IR and retire counter; IFU_TIMEOUT_EN enables fetch timeout
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_en,
  input  logic [31:0] PC_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst_out,
  output logic [25:0] inst_field,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        inst_valid,
  output logic        cpu_stall,
  output logic        fetch_err,
  output logic [31:0] retired_cnt
);

  ifu_state_e state, state_nxt;
  logic       armed;
  logic       expire;

`ifdef IFU_TIMEOUT_EN
  ifu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_REQ),
    .count  ((state == ST_REQ) && !imem_ack),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign expire         = 1'b0;
`endif

  // armed delays the first request to the second edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (ifu_en && armed) state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_ack)    state_nxt = ST_VALID;
        else if (expire) state_nxt = ST_ERR;
      end
      ST_VALID: state_nxt = ifu_en ? ST_REQ : ST_IDLE;
      ST_ERR:   state_nxt = ST_ERR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    cpu_stall  = 1'b1;
    fetch_err  = 1'b0;
    unique case (state)
      ST_IDLE:  ;
      ST_REQ:   imem_req = 1'b1;
      ST_VALID: begin
        inst_valid = 1'b1;
        cpu_stall  = 1'b0;
      end
`ifdef IFU_TIMEOUT_EN
      ST_ERR:   fetch_err = 1'b1;
`else
      ST_ERR:   ;
`endif
      default:  ;
    endcase
  end

  assign imem_addr = imem_req ? PC_out : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_out    <= NOP;
      retired_cnt <= 32'h0000_0000;
    end else begin
      if (state == ST_REQ && imem_ack) inst_out <= imem_data;
      if (state == ST_VALID)           retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign opcode     = inst_out[OPCODE_MSB:OPCODE_LSB];
  assign inst_field = inst_out[FIELD_MSB:FIELD_LSB];
  assign func       = inst_out[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit (timeout section follows IFU_TIMEOUT_EN)
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        ifu_en;
  logic [31:0] PC_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] inst_out;
  logic [25:0] inst_field;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        inst_valid;
  logic        cpu_stall;
  logic        fetch_err;
  logic [31:0] retired_cnt;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_unit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_en      (ifu_en),
    .PC_out      (PC_out),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .inst_out    (inst_out),
    .inst_field  (inst_field),
    .opcode      (opcode),
    .func        (func),
    .inst_valid  (inst_valid),
    .cpu_stall   (cpu_stall),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    ifu_en    = 1'b0;
    PC_out    = 32'h0;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    tick();
    tick();

    check("rst_req",     {31'd0, imem_req},   32'd0);
    check("rst_valid",   {31'd0, inst_valid}, 32'd0);
    check("rst_stall",   {31'd0, cpu_stall},  32'd1);
    check("rst_err",     {31'd0, fetch_err},  32'd0);
    check("rst_retired", retired_cnt,         32'd0);
    check("rst_ir",      inst_out,            32'h0);

    // first fetch: zero-wait ack
    rst    = 1'b1;
    ifu_en = 1'b1;
    tick();
    check("rel_edge1_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("t1_req",   {31'd0, imem_req},  32'd1);
    check("t1_addr",  imem_addr,          32'h0);
    check("t1_stall", {31'd0, cpu_stall}, 32'd1);
    imem_ack  = 1'b1;
    imem_data = 32'h0253_8820;
    tick();
    imem_ack = 1'b0;
    check("t1_valid",   {31'd0, inst_valid}, 32'd1);
    check("t1_stall0",  {31'd0, cpu_stall},  32'd0);
    check("t1_opcode",  {26'd0, opcode},     32'h00);
    check("t1_func",    {26'd0, func},       32'h20);
    check("t1_field",   {6'd0, inst_field},  32'h0253_8820);
    check("t1_ir",      inst_out,            32'h0253_8820);
    PC_out = 32'h0000_0100;
    tick();
    check("t1_retired", retired_cnt,         32'd1);
    check("t1_valid0",  {31'd0, inst_valid}, 32'd0);

    // ack on the 4th REQ cycle
    for (int i = 0; i < 4; i++) begin
      check("t2_req",   {31'd0, imem_req},   32'd1);
      check("t2_addr",  imem_addr,           32'h0000_0100);
      check("t2_stall", {31'd0, cpu_stall},  32'd1);
      check("t2_nval",  {31'd0, inst_valid}, 32'd0);
      if (i == 3) begin
        imem_ack  = 1'b1;
        imem_data = 32'hAC22_0008;
      end
      tick();
    end
    imem_ack = 1'b0;
    check("t2_valid",  {31'd0, inst_valid}, 32'd1);
    check("t2_ir",     inst_out,            32'hAC22_0008);
    check("t2_opcode", {26'd0, opcode},     32'h2B);
    check("t2_noerr",  {31'd0, fetch_err},  32'd0);
    ifu_en = 1'b0;
    tick();
    check("t2_idle_req",   {31'd0, imem_req},   32'd0);
    check("t2_idle_valid", {31'd0, inst_valid}, 32'd0);
    check("t2_retired",    retired_cnt,         32'd2);

    // ack while idle is ignored
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("stray_ir",    inst_out,            32'hAC22_0008);
    check("stray_valid", {31'd0, inst_valid}, 32'd0);
    check("stray_req",   {31'd0, imem_req},   32'd0);

    // ifu_en dropped mid-request
    ifu_en = 1'b1;
    tick();
    check("t4_req1", {31'd0, imem_req}, 32'd1);
    ifu_en = 1'b0;
    tick();
    check("t4_req2", {31'd0, imem_req}, 32'd1);
    imem_ack  = 1'b1;
    imem_data = 32'h8C41_0004;
    tick();
    imem_ack = 1'b0;
    check("t4_valid",  {31'd0, inst_valid}, 32'd1);
    check("t4_opcode", {26'd0, opcode},     32'h23);
    check("t4_field",  {6'd0, inst_field},  32'h0041_0004);
    tick();
    check("t4_idle",   {31'd0, imem_req},   32'd0);
    check("t4_nval",   {31'd0, inst_valid}, 32'd0);
    tick();
    check("t4_park",    {31'd0, imem_req}, 32'd0);
    check("t4_retired", retired_cnt,       32'd3);

    // retire counter wrap
    force dut.retired_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.retired_cnt;
    for (int k = 0; k < 2; k++) begin
      ifu_en = 1'b1;
      tick();
      imem_ack  = 1'b1;
      imem_data = 32'h0000_0020 + k;
      tick();
      imem_ack = 1'b0;
      ifu_en   = 1'b0;
      tick();
      check("wrap_cnt", retired_cnt, (k == 0) ? 32'hFFFF_FFFF : 32'h0);
    end
    check("wrap_ir",  inst_out,           32'h0000_0021);
    check("wrap_err", {31'd0, fetch_err}, 32'd0);

    // asynchronous reset in the middle of a request
    ifu_en = 1'b1;
    tick();
    check("t5_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_req_drop", {31'd0, imem_req},  32'd0);
    check("t5_ir",       inst_out,           32'h0);
    check("t5_stall",    {31'd0, cpu_stall}, 32'd1);
    check("t5_retired",  retired_cnt,        32'd0);
    tick();
    rst       = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    check("t5_late_ack_ir", inst_out,            32'h0);
    check("t5_late_req",    {31'd0, imem_req},   32'd0);
    check("t5_late_val",    {31'd0, inst_valid}, 32'd0);
    tick();
    check("t5_refetch", {31'd0, imem_req}, 32'd1);

`ifdef IFU_TIMEOUT_EN
    // TIMEOUT=4 with no ack
    for (int i = 0; i < 4; i++) begin
      check("to_wait_req", {31'd0, imem_req},  32'd1);
      check("to_wait_err", {31'd0, fetch_err}, 32'd0);
      tick();
    end
    check("to_err",   {31'd0, fetch_err},  32'd1);
    check("to_req",   {31'd0, imem_req},   32'd0);
    check("to_stall", {31'd0, cpu_stall},  32'd1);
    check("to_nval",  {31'd0, inst_valid}, 32'd0);
    imem_ack = 1'b1;
    tick();
    tick();
    imem_ack = 1'b0;
    check("to_sticky",    {31'd0, fetch_err}, 32'd1);
    check("to_sticky_ir", inst_out,           32'h0);
    rst = 1'b0;
    #1;
    check("to_rst_clr", {31'd0, fetch_err}, 32'd0);
    tick();
    rst = 1'b1;
`else
    // without the timeout feature the request waits indefinitely
    for (int i = 0; i < 20; i++) tick();
    check("nt_req",   {31'd0, imem_req},  32'd1);
    check("nt_err",   {31'd0, fetch_err}, 32'd0);
    imem_ack  = 1'b1;
    imem_data = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("nt_valid", {31'd0, inst_valid}, 32'd1);
    check("nt_ir",    inst_out,            32'h1234_5678);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
